mem_arbiter: RTL and testbench

//  Shared-memory front end downstream of cpu: consumes I-cache (fetch) and
//  D-cache (MEM stage) miss requests, serialises them onto one multicycle

---
 rtl/mem_arbiter_pkg.sv | 35 +++
 rtl/mem_arbiter_block_word_counter.sv | 39 +++
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared constants, state/owner encodings and address helpers for mem_arbiter
package mem_arbiter_pkg;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int BLOCK_WORDS = 8;
  localparam int CNT_W       = $clog2(BLOCK_WORDS);

  // Byte-offset bits inside one 16-byte cache block
  localparam logic [ADDR_W-1:0] OFFSET_MASK = 16'h000F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Aligned base of the block holding a byte address
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return addr & ~OFFSET_MASK;
  endfunction

  // Byte address of word idx inside the block; the base is aligned, so no carry leaves the block
  function automatic logic [ADDR_W-1:0] block_word_addr(input logic [ADDR_W-1:0] base,
                                                        input logic [CNT_W-1:0]  idx);
    return base + ADDR_W'({idx, 1'b0});
  endfunction

endpackage

// File: rtl/mem_arbiter_block_word_counter.sv
// rtl/mem_arbiter_block_word_counter.sv - word index counter over one cache block with terminal-count flag
module mem_arbiter_block_word_counter
  import mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over enable; wraps naturally after the last word
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // High in the cycle the last word of the block is counted
  assign wrap_o  = en_i & (count_q == CNT_W'(BLOCK_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises I/D cache misses and D stores onto one multicycle memory
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] i_data,
  output logic [ADDR_W-1:0] i_word_addr,
  output logic              i_we,
  output logic              i_busy,
  output logic [DATA_W-1:0] d_data,
  output logic [ADDR_W-1:0] d_word_addr,
  output logic              d_we,
  output logic              d_busy,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] st_addr_q, st_addr_d;
  logic [DATA_W-1:0] st_data_q, st_data_d;
  logic              issue_done_q, issue_done_d;
  // One-cycle markers: the side whose transaction just finished, seen in the following IDLE cycle
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;

  logic              in_fill;
  logic              issue_en;
  logic              recv_en;
  logic              cnt_clear;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  recv_cnt;
  logic              issue_wrap;
  logic              recv_wrap;
  logic              i_take;
  logic              d_take;

  assign in_fill   = (state_q == ST_FILL);
  assign issue_en  = in_fill & ~issue_done_q;
  assign recv_en   = in_fill & mem_rvalid;
  assign cnt_clear = ~in_fill;

  // A side that was just served still holds its request for one cycle; ignore it then
  assign i_take = i_req & ~i_done_q;
  assign d_take = d_req & ~d_done_q;

  mem_arbiter_block_word_counter u_issue_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (cnt_clear),
    .en_i    (issue_en),
    .count_o (issue_cnt),
    .wrap_o  (issue_wrap)
  );

  mem_arbiter_block_word_counter u_recv_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (cnt_clear),
    .en_i    (recv_en),
    .count_o (recv_cnt),
    .wrap_o  (recv_wrap)
  );

  // State and transaction context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      base_q       <= '0;
      st_addr_q    <= '0;
      st_data_q    <= '0;
      issue_done_q <= 1'b0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      base_q       <= base_d;
      st_addr_q    <= st_addr_d;
      st_data_q    <= st_data_d;
      issue_done_q <= issue_done_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
    end
  end

  // Arbitration (D beats I) and fill/write sequencing
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    base_d       = base_q;
    st_addr_d    = st_addr_q;
    st_data_d    = st_data_q;
    issue_done_d = issue_done_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (d_take && d_wr) begin
          state_d   = ST_WRITE;
          owner_d   = OWN_D;
          st_addr_d = d_addr;
          st_data_d = d_wdata;
        end else if (d_take) begin
          state_d      = ST_FILL;
          owner_d      = OWN_D;
          base_d       = block_base(d_addr);
          issue_done_d = 1'b0;
        end else if (i_take) begin
          state_d      = ST_FILL;
          owner_d      = OWN_I;
          base_d       = block_base(i_addr);
          issue_done_d = 1'b0;
        end
      end
      ST_WRITE: begin
        state_d  = ST_IDLE;
        owner_d  = OWN_NONE;
        d_done_d = 1'b1;
      end
      ST_FILL: begin
        if (issue_wrap) begin
          issue_done_d = 1'b1;
        end
        // Reads are in order, so the last returned word closes the fill
        if (recv_wrap) begin
          state_d  = ST_IDLE;
          owner_d  = OWN_NONE;
          i_done_d = (owner_q == OWN_I);
          d_done_d = (owner_q == OWN_D);
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Memory strobes, fill write strobes and per-side stalls
  always_comb begin
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_we        = 1'b0;
    i_data      = '0;
    i_word_addr = '0;
    d_we        = 1'b0;
    d_data      = '0;
    d_word_addr = '0;
    case (state_q)
      ST_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = st_addr_q;
        mem_wdata = st_data_q;
      end
      ST_FILL: begin
        if (!issue_done_q) begin
          mem_en   = 1'b1;
          mem_addr = block_word_addr(base_q, issue_cnt);
        end
        if (mem_rvalid && owner_q == OWN_I) begin
          i_we        = 1'b1;
          i_data      = mem_rdata;
          i_word_addr = block_word_addr(base_q, recv_cnt);
        end
        if (mem_rvalid && owner_q == OWN_D) begin
          d_we        = 1'b1;
          d_data      = mem_rdata;
          d_word_addr = block_word_addr(base_q, recv_cnt);
        end
      end
      default: begin
      end
    endcase
    // Busy is masked during reset so that every output reads 0 while rst_n is low
    i_busy = rst_n & i_req & ~((state_q == ST_IDLE) & i_done_q);
    d_busy = rst_n & d_req & ~((state_q == ST_IDLE) & d_done_q);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a 4-cycle memory model
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [15:0] i_data, i_word_addr, d_data, d_word_addr;
  logic        i_we, i_busy, d_we, d_busy;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata  = 16'h0000;
  logic        mem_rvalid = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  int          tick = 0;
  int          stall_from = -100;
  int          stall_len = 0;
  logic        spur = 1'b0;
  logic        cap_rd = 1'b0;
  logic [15:0] cap_addr = 16'h0000;
  logic [15:0] pend_q[$];
  int          due_q[$];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_data(i_data), .i_word_addr(i_word_addr), .i_we(i_we), .i_busy(i_busy),
    .d_data(d_data), .d_word_addr(d_word_addr), .d_we(d_we), .d_busy(d_busy),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  // Memory model: capture the read strobe mid-cycle, return data LAT cycles later
  always @(negedge clk) begin
    cap_rd   = mem_en & ~mem_wr;
    cap_addr = mem_addr;
  end

  always @(posedge clk) begin
    tick = tick + 1;
    if (!rst_n) begin
      pend_q.delete();
      due_q.delete();
    end else if (cap_rd) begin
      pend_q.push_back(cap_addr);
      due_q.push_back(tick + LAT - 1);
    end
    #1;
    mem_rvalid = spur;
    mem_rdata  = spur ? 16'h1111 : 16'h0000;
    if (rst_n && due_q.size() > 0 && due_q[0] <= tick &&
        !(tick >= stall_from && tick < stall_from + stall_len)) begin
      mem_rvalid = 1'b1;
      mem_rdata  = pend_q[0] ^ 16'hA5A5;
      pend_q.pop_front();
      due_q.pop_front();
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of cycle 0 with the owner's request already driven
  task automatic expect_fill(input string tag, input bit own_d, input logic [15:0] base,
                             input int ss, input int sl, input logic oth_busy);
    int          w;
    logic        exp_en, exp_we;
    logic [15:0] exp_ma, exp_wa, exp_dt;
    w          = 0;
    stall_from = tick + ss;
    stall_len  = sl;
    #1;
    check({tag, "_c0_busy"}, own_d ? d_busy : i_busy, 1'b1);
    check({tag, "_c0_oth_busy"}, own_d ? i_busy : d_busy, oth_busy);
    check({tag, "_c0_en"}, mem_en, 1'b0);
    for (int c = 1; c <= 30 && w < 8; c++) begin
      @(negedge clk);
      exp_en = (c <= 8);
      exp_ma = exp_en ? base + 16'(2 * (c - 1)) : 16'h0000;
      exp_we = (c >= 5) && !(c >= ss && c < ss + sl);
      exp_wa = exp_we ? base + 16'(2 * w) : 16'h0000;
      exp_dt = exp_we ? (exp_wa ^ 16'hA5A5) : 16'h0000;
      check({tag, "_en"}, mem_en, exp_en);
      check({tag, "_wr"}, mem_wr, 1'b0);
      check({tag, "_maddr"}, mem_addr, exp_ma);
      check({tag, "_we"}, own_d ? d_we : i_we, exp_we);
      check({tag, "_waddr"}, own_d ? d_word_addr : i_word_addr, exp_wa);
      check({tag, "_data"}, own_d ? d_data : i_data, exp_dt);
      check({tag, "_busy"}, own_d ? d_busy : i_busy, 1'b1);
      check({tag, "_oth_we"}, own_d ? i_we : d_we, 1'b0);
      check({tag, "_oth_data"}, own_d ? i_data : d_data, 16'h0000);
      check({tag, "_oth_busy"}, own_d ? i_busy : d_busy, oth_busy);
      if (exp_we) w++;
    end
    check({tag, "_words"}, 64'(w), 64'd8);
    @(negedge clk);
    check({tag, "_end_busy"}, own_d ? d_busy : i_busy, 1'b0);
    check({tag, "_end_oth_busy"}, own_d ? i_busy : d_busy, oth_busy);
    check({tag, "_end_en"}, mem_en, 1'b0);
    check({tag, "_end_we"}, own_d ? d_we : i_we, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; i_req = 1'b0; i_addr = 16'h0; d_req = 1'b0; d_wr = 1'b0;
    d_addr = 16'h0; d_wdata = 16'h0;
    repeat (2) @(negedge clk);
    i_req = 1'b1;
    #1;
    check("reset_ctl", {mem_en, mem_wr, mem_addr, mem_wdata, i_we, d_we, i_busy, d_busy}, 64'h0);
    check("reset_data", {i_data, i_word_addr, d_data, d_word_addr}, 64'h0);
    i_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Stray read data while idle must not be written anywhere
    spur = 1'b1;
    @(negedge clk);
    check("spur_i_we", i_we, 1'b0);
    check("spur_d_we", d_we, 1'b0);
    check("spur_i_data", i_data, 16'h0000);
    spur = 1'b0;
    @(negedge clk);
    check("spur_idle", {mem_en, i_busy, d_busy}, 64'h0);

    // Lone I miss
    i_req = 1'b1; i_addr = 16'h1234;
    expect_fill("ifill", 1'b0, 16'h1230, 0, 0, 1'b0);
    i_req = 1'b0;
    @(negedge clk);

    // Simultaneous I and D misses: D first, I right after
    i_req = 1'b1; i_addr = 16'h2468;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
    expect_fill("dfirst", 1'b1, 16'h0040, 0, 0, 1'b1);
    d_req = 1'b0;
    expect_fill("ithen", 1'b0, 16'h2460, 0, 0, 1'b0);
    i_req = 1'b0;
    @(negedge clk);

    // D write-through store
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0102; d_wdata = 16'hBEEF;
    #1;
    check("st_c0_busy", d_busy, 1'b1);
    check("st_c0_en", mem_en, 1'b0);
    @(negedge clk);
    check("st_en", {mem_en, mem_wr}, 64'h3);
    check("st_addr", mem_addr, 16'h0102);
    check("st_wdata", mem_wdata, 16'hBEEF);
    check("st_we", {i_we, d_we}, 64'h0);
    check("st_busy", d_busy, 1'b1);
    @(negedge clk);
    check("st_end", {mem_en, mem_wr, d_we, d_busy}, 64'h0);
    d_req = 1'b0; d_wr = 1'b0;
    @(negedge clk);

    // Memory withholds read data for 3 cycles mid-fill
    i_req = 1'b1; i_addr = 16'h5678;
    expect_fill("stall", 1'b0, 16'h5670, 8, 3, 1'b0);
    i_req = 1'b0;
    @(negedge clk);

    // Reset in cycle 6 of a fill
    i_req = 1'b1; i_addr = 16'h1234;
    repeat (6) @(negedge clk);
    check("mid_we", i_we, 1'b1);
    check("mid_waddr", i_word_addr, 16'h1232);
    rst_n = 1'b0;
    #1;
    check("rst_ctl", {mem_en, mem_wr, mem_addr, mem_wdata, i_we, d_we, i_busy, d_busy}, 64'h0);
    check("rst_data", {i_data, i_word_addr, d_data, d_word_addr}, 64'h0);
    i_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'hFFF0;
    expect_fill("top", 1'b0, 16'hFFF0, 0, 0, 1'b0);
    i_req = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
